// File: rtl/joy_input.sv
// joy_input: conditions raw board inputs (five joystick buttons, eight slide
// switches) into clean, clock-synchronous levels and one-cycle event pulses.
// Every channel is synchronised with two flops and debounced on its own.
// Joystick channels add a press auto-repeat while the button is held.
//
// Handshake note: this block has no valid/ready traffic. Every event output
// is a registered single-cycle pulse aligned with the matching *_state
// change, and consumers sample it on the same rising edge of clk.
module joy_input #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic       joy_select,
    input  logic [7:0] switch,
    output logic [4:0] joy_state,
    output logic [4:0] joy_press,
    output logic [4:0] joy_release,
    output logic [7:0] switch_state,
    output logic       switch_changed
);

    // Channel map: [4:0] joystick {select,right,left,down,up}, [12:5] switches.
    localparam int NJOY = 5;
    localparam int NSW  = 8;
    localparam int NCH  = NJOY + NSW;

    // Debounce counter only has to hold values up to DEBOUNCE_CYCLES-1,
    // since the level flips on the cycle the count would reach DEBOUNCE_CYCLES.
    localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    // Repeat counter is shared between the DELAY and REPEAT phases, so it is
    // sized for the longer of the two intervals (and at least one bit).
    localparam int RMAX0 = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RMAX  = (RMAX0 < 1) ? 1 : RMAX0;
    localparam int RW    = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
    localparam logic [RW-1:0] RP_LAST = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

    // Per-joystick-channel auto-repeat state.
    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    logic [NCH-1:0]  raw;
    logic [NCH-1:0]  s1;
    logic [NCH-1:0]  s2;
    logic [NCH-1:0]  stable;
    logic [NCH-1:0]  flip;
    logic [NJOY-1:0] rise;
    logic [NJOY-1:0] fall;
    logic [NJOY-1:0] press_next;

    // Repeat FSM state of every joystick channel, visible for debug/checkers.
    rep_state_t rep_state_dbg [NJOY];

    assign raw = {switch, joy_select, joy_right, joy_left, joy_down, joy_up};

    // Two-flop synchroniser for all channels; raw pins are asynchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-channel debouncer: counts consecutive cycles where the synchronised
    // input disagrees with the stable level; any agreement restarts the count.
    for (genvar ch = 0; ch < NCH; ch++) begin : g_db
        logic           stable_q;
        logic [DBW-1:0] cnt_q;

        // Debounce counter and stable level register.
        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else if (s2[ch] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                stable_q <= s2[ch];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + DBW'(1);
            end
        end

        assign stable[ch] = stable_q;
        // Flip is the combinational "stable level changes at this edge" strobe.
        assign flip[ch]   = (s2[ch] != stable_q) && (cnt_q == DB_LAST);
    end

    assign rise = flip[NJOY-1:0] & s2[NJOY-1:0];
    assign fall = flip[NJOY-1:0] & ~s2[NJOY-1:0];

    // Per-joystick auto-repeat FSM.
    for (genvar j = 0; j < NJOY; j++) begin : g_rep
        rep_state_t    state_q;
        rep_state_t    state_d;
        logic [RW-1:0] rcnt_q;
        logic [RW-1:0] rcnt_d;
        logic          press_d;

        // Repeat FSM state and interval counter registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= REP_IDLE;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        // Next-state and press decision; a debounced fall always wins over a
        // repeat that would otherwise fire on the same cycle.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            press_d = 1'b0;
            case (state_q)
                REP_IDLE: begin
                    if (rise[j]) begin
                        press_d = 1'b1;
                        // With no repeat delay the channel just sits in IDLE while held.
                        if (REPEAT_DELAY != 0) begin
                            state_d = REP_DELAY;
                            rcnt_d  = '0;
                        end
                    end
                end
                REP_DELAY: begin
                    if (fall[j]) begin
                        state_d = REP_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RD_LAST) begin
                        press_d = 1'b1;
                        state_d = REP_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                REP_REPEAT: begin
                    if (fall[j]) begin
                        state_d = REP_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RP_LAST) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = REP_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        assign press_next[j]    = press_d;
        assign rep_state_dbg[j] = state_q;
    end

    // Registered event pulses, aligned with the stable level update.
    always_ff @(posedge clk) begin
        if (reset) begin
            joy_press      <= '0;
            joy_release    <= '0;
            switch_changed <= 1'b0;
        end else begin
            joy_press      <= press_next;
            joy_release    <= fall;
            switch_changed <= |flip[NCH-1:NJOY];
        end
    end

    assign joy_state    = stable[NJOY-1:0];
    assign switch_state = stable[NCH-1:NJOY];

endmodule

// File: tb/tb_joy_input.sv
// Directed testbench for joy_input with short debounce/repeat parameters.
// Outputs are sampled 1 time unit after each rising edge; inputs change at
// the same point, so they are captured by the next rising edge ("edge 0").
module tb_joy_input;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       joy_up = 1'b0;
    logic       joy_down = 1'b0;
    logic       joy_left = 1'b0;
    logic       joy_right = 1'b0;
    logic       joy_select = 1'b0;
    logic [7:0] switch = 8'h00;
    logic [4:0] joy_state;
    logic [4:0] joy_press;
    logic [4:0] joy_release;
    logic [7:0] switch_state;
    logic       switch_changed;

    int n_asserts = 0;
    int n_fail    = 0;

    joy_input #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .joy_up        (joy_up),
        .joy_down      (joy_down),
        .joy_left      (joy_left),
        .joy_right     (joy_right),
        .joy_select    (joy_select),
        .switch        (switch),
        .joy_state     (joy_state),
        .joy_press     (joy_press),
        .joy_release   (joy_release),
        .switch_state  (switch_state),
        .switch_changed(switch_changed)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_joy_state"},   8'(joy_state),      8'h00);
        check({tag, "_joy_press"},   8'(joy_press),      8'h00);
        check({tag, "_joy_release"}, 8'(joy_release),    8'h00);
        check({tag, "_sw_state"},    switch_state,       8'h00);
        check({tag, "_sw_changed"},  8'(switch_changed), 8'h00);
    endtask

    initial begin
        // Reset with all inputs low.
        reset = 1'b1;
        tick_n(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick_n(2);
        check_all_zero("post_reset");

        // joy_select rise: state and press appear at edge 5, press for one cycle.
        joy_select = 1'b1;
        tick_n(5);
        check("sel_state_e4", 8'(joy_state), 8'h00);
        check("sel_press_e4", 8'(joy_press), 8'h00);
        tick();
        check("sel_state_e5", 8'(joy_state), 8'h10);
        check("sel_press_e5", 8'(joy_press), 8'h10);
        tick();
        check("sel_state_e6", 8'(joy_state), 8'h10);
        check("sel_press_e6", 8'(joy_press), 8'h00);

        // joy_select fall: release 6 edges later, no press alongside.
        joy_select = 1'b0;
        tick_n(5);
        check("sel_rel_e4",   8'(joy_release), 8'h00);
        check("sel_state_f4", 8'(joy_state),   8'h10);
        tick();
        check("sel_rel_e5",   8'(joy_release), 8'h10);
        check("sel_state_f5", 8'(joy_state),   8'h00);
        check("sel_press_f5", 8'(joy_press),   8'h00);
        tick();
        check("sel_rel_e6",   8'(joy_release), 8'h00);

        // Glitch on joy_up for 3 cycles: no activity at all.
        joy_up = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) joy_up = 1'b0;
            tick();
            check("glitch_state", 8'(joy_state),   8'h00);
            check("glitch_press", 8'(joy_press),   8'h00);
            check("glitch_rel",   8'(joy_release), 8'h00);
        end

        // Hold joy_left 60 cycles: press at edges 5,25,33,41,49,57; release at 65
        // (where a repeat would otherwise have fired).
        joy_left = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i == 60) joy_left = 1'b0;
            tick();
            check("left_press", 8'(joy_press),
                  (i == 5 || i == 25 || i == 33 || i == 41 || i == 49 || i == 57) ? 8'h04 : 8'h00);
            check("left_rel",   8'(joy_release), (i == 65) ? 8'h04 : 8'h00);
            check("left_state", 8'(joy_state),   (i >= 5 && i < 65) ? 8'h04 : 8'h00);
        end

        // Switches: settle at 8'h80, then jump to 8'h01 in one cycle.
        switch = 8'h80;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("sw80_state",   switch_state,       (i >= 5) ? 8'h80 : 8'h00);
            check("sw80_changed", 8'(switch_changed), (i == 5) ? 8'h01 : 8'h00);
        end
        switch = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sw01_state",   switch_state,       (i >= 5) ? 8'h01 : 8'h80);
            check("sw01_changed", 8'(switch_changed), (i == 5) ? 8'h01 : 8'h00);
        end

        // Two-cycle bounce on switch bit 3: no change.
        switch = 8'h09;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) switch = 8'h01;
            tick();
            check("bounce_state",   switch_state,       8'h01);
            check("bounce_changed", 8'(switch_changed), 8'h00);
        end

        // joy_down held into REPEAT, then reset mid-repeat.
        joy_down = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tick();
            check("down_press", 8'(joy_press),
                  (i == 5 || i == 25 || i == 33) ? 8'h02 : 8'h00);
        end
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        // Input still high: fresh press after 6 edges, first repeat 20 later;
        // the switch value also re-debounces as a fresh change.
        for (int i = 0; i < 31; i++) begin
            tick();
            check("rst_down_press", 8'(joy_press),   (i == 5 || i == 25) ? 8'h02 : 8'h00);
            check("rst_down_state", 8'(joy_state),   (i >= 5) ? 8'h02 : 8'h00);
            check("rst_down_rel",   8'(joy_release), 8'h00);
            check("rst_sw_state",   switch_state,       (i >= 5) ? 8'h01 : 8'h00);
            check("rst_sw_changed", 8'(switch_changed), (i == 5) ? 8'h01 : 8'h00);
        end
        joy_down = 1'b0;
        tick_n(6);
        check("down_rel", 8'(joy_release), 8'h02);
        tick_n(4);

        // Simultaneous rise of up and right: one combined press cycle.
        joy_up    = 1'b1;
        joy_right = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("dual_press", 8'(joy_press), (i == 5) ? 8'h09 : 8'h00);
            check("dual_state", 8'(joy_state), (i >= 5) ? 8'h09 : 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
